// File: rtl/bist_pkg.sv
// Shared BIST definitions: checker FSM states, default MISR geometry and the
// MISR next-state function used by the checker and the pattern generator.
package bist_pkg;

  localparam int unsigned MISR_MAX_W    = 64;
  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_POLY = 16'h002D;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_COMPACT = 3'd2,
    S_CHECK   = 3'd3,
    S_DONE    = 3'd4
  } bist_state_e;

  // One MISR step on a 'width'-bit register held in the low bits of a wide word.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input logic [MISR_MAX_W-1:0] poly,
    input int unsigned           width
  );
    logic [MISR_MAX_W-1:0] mask;
    logic                  msb;
    mask = (width >= MISR_MAX_W) ? '1 : ((MISR_MAX_W'(1) << width) - MISR_MAX_W'(1));
    msb  = |((sig >> (width - 1)) & MISR_MAX_W'(1));
    return ((sig << 1) ^ (msb ? poly : '0) ^ data) & mask;
  endfunction

endpackage

// File: rtl/bist_misr_reg.sv
// WIDTH-bit multiple-input signature register with seed load and step enables.
module bist_misr_reg
  import bist_pkg::*;
#(
  parameter int unsigned       WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  POLY  = DEFAULT_POLY,
  parameter logic [WIDTH-1:0]  SEED  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_step_c;

  assign sig_step_c = WIDTH'(misr_next(MISR_MAX_W'(sig), MISR_MAX_W'(data),
                                       MISR_MAX_W'(POLY), WIDTH));

  // Load wins over step so an init always reseeds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig <= '0;
    end else if (load) begin
      sig <= SEED;
    end else if (step) begin
      sig <= sig_step_c;
    end
  end

endmodule

// File: rtl/bist_misr_checker.sv
// BIST response checker: seeds and steps the MISR under controller strobes,
// counts compaction cycles and latches a pass/fail verdict on finish.
module bist_misr_checker
  import bist_pkg::*;
#(
  parameter int unsigned       WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  POLY    = DEFAULT_POLY,
  parameter logic [WIDTH-1:0]  SEED    = '0,
  parameter logic [WIDTH-1:0]  GOLDEN  = '0,
  parameter int unsigned       NCYCLES = 651,
  localparam int unsigned      CW      = $clog2(NCYCLES + 1) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             running,
  input  logic             finish,
  input  logic [WIDTH-1:0] cut_out,
  output logic [WIDTH-1:0] signature,
  output logic [CW-1:0]    cycles,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  localparam logic [CW-1:0] CYCLES_GOLDEN = CW'(NCYCLES);

  bist_state_e state, state_next;
  logic        load_c;
  logic        step_c;
  logic        match_c;

  bist_misr_reg #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .reset (reset),
    .load  (load_c),
    .step  (step_c),
    .data  (cut_out),
    .sig   (signature)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next state and MISR enables; init overrides every state.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    step_c     = 1'b0;
    if (init) begin
      load_c     = 1'b1;
      state_next = S_ARMED;
    end else begin
      unique case (state)
        S_ARMED, S_COMPACT: begin
          step_c = running;
          if (finish)       state_next = S_CHECK;
          else if (running) state_next = S_COMPACT;
        end
        S_CHECK: state_next = S_DONE;
        default: state_next = state;
      endcase
    end
  end

  assign match_c = (signature == GOLDEN) && (cycles == CYCLES_GOLDEN);

  // Saturating compaction counter and latched verdict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles <= '0;
      done   <= 1'b0;
      pass   <= 1'b0;
      fail   <= 1'b0;
    end else if (load_c) begin
      cycles <= '0;
      done   <= 1'b0;
      pass   <= 1'b0;
      fail   <= 1'b0;
    end else begin
      if (step_c && (cycles != '1)) cycles <= cycles + CW'(1);
      if (state == S_CHECK) begin
        done <= 1'b1;
        pass <= match_c;
        fail <= !match_c;
      end
    end
  end

endmodule

// File: tb/tb_bist_misr_checker.sv
// Self-checking bench for bist_misr_checker with a polynomial-arithmetic model.
module tb_bist_misr_checker;

  localparam int unsigned W    = 4;
  localparam int unsigned NC   = 7;
  localparam int unsigned CW   = $clog2(NC + 1) + 1;
  localparam int unsigned CMAX = (1 << CW) - 1;
  localparam logic [W-1:0] POLY = 4'h3;
  localparam logic [W-1:0] SEED = 4'h0;
  localparam logic [W-1:0] GOLD = 4'h9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0;
  logic          running = 1'b0;
  logic          finish = 1'b0;
  logic [W-1:0]  cut_out = '0;
  logic [W-1:0]  signature;
  logic [CW-1:0] cycles;
  logic          done, pass, fail;

  int checks = 0;
  int failures = 0;

  bist_misr_checker #(
    .WIDTH   (W),
    .POLY    (POLY),
    .SEED    (SEED),
    .GOLDEN  (GOLD),
    .NCYCLES (NC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .running   (running),
    .finish    (finish),
    .cut_out   (cut_out),
    .signature (signature),
    .cycles    (cycles),
    .done      (done),
    .pass      (pass),
    .fail      (fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Signature as polynomial arithmetic over GF(2): s = s*x mod P(x) + d.
  function automatic logic [W-1:0] model_sig(input logic [W-1:0] d[$]);
    int unsigned s;
    s = SEED;
    foreach (d[i]) begin
      s = s * 2;
      if (s >= (1 << W)) s = s ^ ((1 << W) | POLY);
      s = s ^ d[i];
    end
    return W'(s);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_sig"},  32'(signature), 32'(0));
    check({tag, "_cyc"},  32'(cycles),    32'(0));
    check({tag, "_done"}, 32'(done),      32'(0));
    check({tag, "_pass"}, 32'(pass),      32'(0));
    check({tag, "_fail"}, 32'(fail),      32'(0));
  endtask

  // init, stream d under running (optional gaps), finish, then check verdict.
  task automatic do_run(input logic [W-1:0] d[$], input bit gaps,
                        input bit fin_with_last, input string tag);
    logic [W-1:0] pre[$];
    logic [W-1:0] exp_sig;
    int unsigned  exp_cyc;
    bit           exp_pass;
    init = 1'b1;
    tick();
    init = 1'b0;
    check({tag, "_seed"},      32'(signature), 32'(SEED));
    check({tag, "_armed_done"}, 32'(done),     32'(0));
    foreach (d[i]) begin
      running = 1'b1;
      cut_out = d[i];
      finish  = fin_with_last && (i == d.size() - 1);
      tick();
      running = 1'b0;
      finish  = 1'b0;
      pre.push_back(d[i]);
      check($sformatf("%s_step%0d", tag, i), 32'(signature), 32'(model_sig(pre)));
      if (gaps && ($urandom_range(0, 2) == 0) && !(fin_with_last && (i == d.size() - 1))) begin
        cut_out = W'($urandom);
        tick();
        check($sformatf("%s_gap%0d", tag, i), 32'(signature), 32'(model_sig(pre)));
      end
    end
    if (!fin_with_last || (d.size() == 0)) begin
      finish = 1'b1;
      tick();
      finish = 1'b0;
    end
    check({tag, "_check_done"}, 32'(done), 32'(0));
    tick();
    exp_sig  = model_sig(d);
    exp_cyc  = (d.size() > CMAX) ? CMAX : d.size();
    exp_pass = (exp_sig == GOLD) && (d.size() == NC);
    check({tag, "_sig"},  32'(signature), 32'(exp_sig));
    check({tag, "_cyc"},  32'(cycles),    32'(exp_cyc));
    check({tag, "_done"}, 32'(done),      32'(1));
    check({tag, "_pass"}, 32'(pass),      32'(exp_pass));
    check({tag, "_fail"}, 32'(fail),      32'(!exp_pass));
  endtask

  initial begin
    logic [W-1:0] d[$];
    logic [W-1:0] held_sig;

    // Reset state and IDLE ignoring running/finish.
    tick();
    tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    running = 1'b1;
    cut_out = 4'hF;
    tick();
    finish = 1'b1;
    tick();
    running = 1'b0;
    finish  = 1'b0;
    tick();
    tick();
    check_idle_outputs("idle_ignore");

    // Golden stream.
    d = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    do_run(d, 1'b0, 1'b0, "t1");
    check("t1_golden_sig", 32'(signature), 32'h9);

    // Corrupted third word.
    d = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    do_run(d, 1'b0, 1'b0, "t2");

    // One cycle short.
    d = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    do_run(d, 1'b0, 1'b0, "t3");

    // Golden stream with gaps, and with finish coincident with the last step.
    d = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    do_run(d, 1'b1, 1'b0, "gaps");
    do_run(d, 1'b0, 1'b1, "fin_last");

    // finish straight from ARMED, then DONE ignores running/finish.
    d = {};
    do_run(d, 1'b0, 1'b0, "t4");
    held_sig = signature;
    for (int i = 0; i < 3; i++) begin
      running = 1'b1;
      finish  = (i == 1);
      cut_out = W'($urandom);
      tick();
    end
    running = 1'b0;
    finish  = 1'b0;
    tick();
    check("t4_hold_sig",  32'(signature), 32'(held_sig));
    check("t4_hold_cyc",  32'(cycles),    32'(0));
    check("t4_hold_done", 32'(done),      32'(1));
    check("t4_hold_fail", 32'(fail),      32'(1));
    check("t4_hold_pass", 32'(pass),      32'(0));

    // Random streams, mostly 7 long so the cycle count matches.
    for (int r = 0; r < 6; r++) begin
      d = {};
      for (int k = 0; k < ((r == 5) ? 20 : NC); k++) d.push_back(W'($urandom));
      do_run(d, 1'b1, r[0], $sformatf("rnd%0d", r));
    end

    // Re-init out of a passing DONE clears verdict, then passes again.
    d = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    do_run(d, 1'b0, 1'b0, "t6a");
    init = 1'b1;
    tick();
    init = 1'b0;
    check_idle_outputs("t6_reinit");
    do_run(d, 1'b0, 1'b0, "t6b");

    // Asynchronous reset mid-compaction.
    init = 1'b1;
    tick();
    init = 1'b0;
    running = 1'b1;
    cut_out = 4'h5;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("t5_async");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cut_out = W'($urandom);
      tick();
    end
    finish = 1'b1;
    tick();
    running = 1'b0;
    finish  = 1'b0;
    tick();
    tick();
    check_idle_outputs("t5_idle");
    do_run(d, 1'b0, 1'b0, "t5_rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bist_misr_checker.md
Name: bist_misr_checker

Overview:
Downstream stage of the BIST controller. Seeds a multiple-input signature register (MISR) on the controller's init strobe, compacts the CUT response every cycle the controller's running is high, and compares the signature and compaction-cycle count against golden values when finish arrives. Provides the latched pass/fail verdict read alongside bist_end.

Parameters:
WIDTH, 16, MISR and CUT response width (>=2)
POLY, 16'h002D, feedback tap mask XORed in when the MSB shifts out (x^16 term implicit)
SEED, 16'h0000, MISR value loaded on init
GOLDEN, 16'h0000, expected final signature (set per CUT build)
NCYCLES, 651, expected number of running-high cycles (controller NCLOCK+1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
init  input  1  controller init strobe, 1-cycle
running  input  1  controller running qualifier
finish  input  1  controller finish strobe, 1-cycle
cut_out  input  WIDTH  CUT response sampled on cycles where running=1
signature  output  WIDTH  current MISR contents
cycles  output  $clog2(NCYCLES+1)+1  compaction cycle count, saturating
done  output  1  verdict valid, held high until next init or reset
pass  output  1  signature==GOLDEN and cycles==NCYCLES; valid while done
fail  output  1  complement of pass while done; 0 otherwise

Behaviour:
- Reset (async): state=IDLE, signature=0, cycles=0, done=pass=fail=0.
- States: IDLE, ARMED, COMPACT, CHECK, DONE.
- init=1 in any state (highest priority): signature<=SEED, cycles<=0, done/pass/fail<=0, ->ARMED.
- IDLE: running and finish ignored; stays IDLE.
- ARMED: running=1 -> one compaction step, ->COMPACT; finish=1 -> CHECK (count 0, will fail).
- COMPACT: running=1 -> compaction step; finish=1 -> CHECK; running=0 and finish=0 -> hold (gap cycles not compacted).
- Compaction step: sig_next = {sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0) ^ cut_out; cycles<=cycles+1, saturating at all-ones.
- running and finish high together: compaction step performed, then ->CHECK.
- CHECK (one cycle): pass<=(signature==GOLDEN)&&(cycles==NCYCLES); fail<=!that; done<=1; ->DONE.
- DONE: holds signature, cycles and verdict; running/finish ignored; leaves only on init or reset.
- Latency: finish sampled on edge t -> CHECK after t -> done/pass/fail high after edge t+1 (2 edges after finish).
- pass and fail are never high together; both 0 while done=0.
- Reset mid-run: verdict cleared, returns to IDLE; a new init is required.

Decomposition:
- Package bist_pkg: state enum (IDLE..DONE), misr_next(sig, data, poly) function, default WIDTH/POLY constants shared with the pattern generator.
- One sub-module, bist_misr_reg: WIDTH-bit register with load (SEED) and step enables; the FSM, counter and comparator stay in the top.

Test Plan (WIDTH=4, POLY=4'h3, SEED=0, GOLDEN=4'h9, NCYCLES=7 unless stated):
1. init; running 7 cycles with cut_out=1,1,1,0,0,0,0; finish -> signature steps 1,3,7,E,F,D,9; cycles=7; done=1, pass=1, fail=0 two edges after finish.
2. Same stream with cut_out[0] flipped on cycle 3 (1,1,0,...) -> signature!=9, fail=1, pass=0.
3. Correct stream but running only 6 cycles then finish -> cycles=6, fail=1.
4. init, finish with no running -> cycles=0, fail=1; then running pulses in DONE -> signature and verdict unchanged.
5. Reset asserted mid-COMPACT (between edges) -> all outputs 0 immediately; running afterwards ignored (IDLE) until init.
6. After DONE with pass=1, init -> done/pass/fail cleared next edge, signature=0; rerun case 1 -> pass=1 again.
